mem_access_unit: RTL and testbench

- MEM-stage load/store initiator that drives the data RAM port: enable, read/write, 32-bit address, 32-bit write data, 2-bit size, and 32-bit read data back.
- Accepts one request at a time from the pipeline through a valid/ready handshake.
- Aligned accesses go out as a single RAM transaction. Unaligned halfword/word accesses are split into sequential byte transactions.
- Loads return data sign- or zero-extended, with a one-cycle response pulse.
- Memory is big-endian: the byte at the lowest address is the most significant.

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response channel of mem_access_unit.
// The master (pipeline) sends one load/store request through a valid/ready
// handshake. The slave (mem_access_unit) returns a one-cycle completion
// pulse with the load data and an error flag.
//   req_valid/req_ready  : request handshake
//   req_rw/addr/wdata    : store (1) or load (0), byte address, right-justified store data
//   req_size/req_signed  : 00 byte, 01 half, 10 word, 11 illegal; sign-extend the load
//   resp_valid/rdata/err : completion pulse, extended load data, error qualifier
//   busy                 : pipeline stall, the inverse of req_ready
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, req_size, req_signed,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, req_size, req_signed,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator driving a big-endian data RAM port.
// Aligned accesses issue one RAM transaction. Unaligned half/word accesses
// are split into sequential byte transactions, or rejected with resp_err
// when ALLOW_UNALIGNED is 0.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   pipe       : request/response channel (slave side)
//   mem_en/rw/addr/din/size : registered RAM command outputs
//   mem_dout   : combinational, right-justified RAM read data
module mem_access_unit #(
    parameter bit ALLOW_UNALIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave pipe,
    output logic             mem_en,
    output logic             mem_rw,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_din,
    output logic [1:0]       mem_size,
    input  logic [31:0]      mem_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    state_t      state, state_n;
    logic [31:0] cap_addr, cap_wdata, acc;
    logic [1:0]  cap_size, idx, idx_inc, idx_last;
    logic        cap_rw, cap_signed, cap_err;
    logic        accept, req_illegal, req_aligned, req_reject;

    logic        mem_en_n, mem_rw_n;
    logic [31:0] mem_addr_n, mem_din_n;
    logic [1:0]  mem_size_n;

    // Byte k of the store value in big-endian order: a halfword is moved to
    // the top of the word first so that byte 0 is always bits [31:24].
    function automatic logic [7:0] be_byte(input logic [31:0] data,
                                           input logic [1:0]  size,
                                           input logic [1:0]  k);
        logic [31:0] v;
        v = (size == 2'b01) ? {data[15:0], 16'h0000} : data;
        v = v << {k, 3'b000};
        return v[31:24];
    endfunction

    assign accept      = pipe.req_valid && (state == IDLE);
    assign req_illegal = (pipe.req_size == 2'b11);
    assign req_aligned = (pipe.req_size == 2'b00) ||
                         (pipe.req_size == 2'b01 && !pipe.req_addr[0]) ||
                         (pipe.req_size == 2'b10 && pipe.req_addr[1:0] == 2'b00);
    assign req_reject  = req_illegal || (!req_aligned && !ALLOW_UNALIGNED);
    assign idx_inc     = idx + 2'd1;
    assign idx_last    = (cap_size == 2'b01) ? 2'd1 : 2'd3;

    assign pipe.req_ready  = (state == IDLE);
    assign pipe.busy       = (state != IDLE);
    assign pipe.resp_valid = (state == RESP);
    assign pipe.resp_err   = (state == RESP) && cap_err;

    always_comb begin
        pipe.resp_rdata = '0;
        if (state == RESP && !cap_err && !cap_rw) begin
            case (cap_size)
                2'b00:   pipe.resp_rdata = {{24{cap_signed & acc[7]}}, acc[7:0]};
                2'b01:   pipe.resp_rdata = {{16{cap_signed & acc[15]}}, acc[15:0]};
                default: pipe.resp_rdata = acc;
            endcase
        end
    end

    // Next state together with the RAM command for the cycle being entered;
    // the command is registered so mem_* are clean flop outputs.
    always_comb begin
        state_n    = state;
        mem_en_n   = 1'b0;
        mem_rw_n   = 1'b0;
        mem_addr_n = '0;
        mem_din_n  = '0;
        mem_size_n = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_reject) begin
                        state_n = RESP;
                    end else if (req_aligned) begin
                        state_n    = ACCESS;
                        mem_en_n   = 1'b1;
                        mem_rw_n   = pipe.req_rw;
                        mem_addr_n = pipe.req_addr;
                        mem_size_n = pipe.req_size;
                        mem_din_n  = pipe.req_wdata;
                    end else begin
                        state_n    = SPLIT;
                        mem_en_n   = 1'b1;
                        mem_rw_n   = pipe.req_rw;
                        mem_addr_n = pipe.req_addr;
                        mem_din_n  = {24'h000000, be_byte(pipe.req_wdata, pipe.req_size, 2'd0)};
                    end
                end
            end
            ACCESS: state_n = RESP;
            SPLIT: begin
                if (idx == idx_last) begin
                    state_n = RESP;
                end else begin
                    mem_en_n   = 1'b1;
                    mem_rw_n   = cap_rw;
                    mem_addr_n = cap_addr + {30'h0, idx_inc};
                    mem_din_n  = {24'h000000, be_byte(cap_wdata, cap_size, idx_inc)};
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_en     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_size   <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_size   <= '0;
            cap_rw     <= 1'b0;
            cap_signed <= 1'b0;
            cap_err    <= 1'b0;
            idx        <= '0;
            acc        <= '0;
        end else begin
            state    <= state_n;
            mem_en   <= mem_en_n;
            mem_rw   <= mem_rw_n;
            mem_addr <= mem_addr_n;
            mem_din  <= mem_din_n;
            mem_size <= mem_size_n;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_addr   <= pipe.req_addr;
                        cap_wdata  <= pipe.req_wdata;
                        cap_size   <= pipe.req_size;
                        cap_rw     <= pipe.req_rw;
                        cap_signed <= pipe.req_signed;
                        cap_err    <= req_reject;
                        idx        <= '0;
                        acc        <= '0;
                    end
                end
                ACCESS: begin
                    if (!cap_rw) acc <= mem_dout;
                end
                SPLIT: begin
                    // Big-endian: earlier bytes end up more significant.
                    if (!cap_rw) acc <= {acc[23:0], mem_dout[7:0]};
                    idx <= idx_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_unit_if p();
    mem_access_unit_if p2();

    logic        mem_en, mem_rw;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [1:0]  mem_size;
    logic        m2_en, m2_rw;
    logic [31:0] m2_addr, m2_din;
    logic [1:0]  m2_size;

    mem_access_unit #(.ALLOW_UNALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .pipe(p),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_size(mem_size), .mem_dout(mem_dout)
    );

    mem_access_unit #(.ALLOW_UNALIGNED(1'b0)) dut2 (
        .clk(clk), .reset(reset), .pipe(p2),
        .mem_en(m2_en), .mem_rw(m2_rw), .mem_addr(m2_addr),
        .mem_din(m2_din), .mem_size(m2_size), .mem_dout(32'h0)
    );

    // ---------------- big-endian byte RAM (256 bytes, address mod 256) ----
    logic [7:0] ram [0:255];
    logic       pk_we = 1'b0;
    logic [7:0] pk_a, pk_d;
    logic [7:0] ra0, ra1, ra2, ra3;
    assign ra0 = mem_addr[7:0];
    assign ra1 = ra0 + 8'd1;
    assign ra2 = ra0 + 8'd2;
    assign ra3 = ra0 + 8'd3;

    always @(posedge clk) begin
        if (pk_we) begin
            ram[pk_a] <= pk_d;
        end else if (mem_en && mem_rw) begin
            case (mem_size)
                2'b00: ram[ra0] <= mem_din[7:0];
                2'b01: begin ram[ra0] <= mem_din[15:8]; ram[ra1] <= mem_din[7:0]; end
                2'b10: begin
                    ram[ra0] <= mem_din[31:24]; ram[ra1] <= mem_din[23:16];
                    ram[ra2] <= mem_din[15:8];  ram[ra3] <= mem_din[7:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_dout = '0;
        case (mem_size)
            2'b00:   mem_dout = {24'h0, ram[ra0]};
            2'b01:   mem_dout = {16'h0, ram[ra0], ram[ra1]};
            default: mem_dout = {ram[ra0], ram[ra1], ram[ra2], ram[ra3]};
        endcase
    end

    // ---------------- checking bookkeeping --------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ------------------------------------
    logic [7:0]  model_mem [0:255];
    logic [31:0] exp_addr [4];
    logic [31:0] exp_din  [4];
    logic [1:0]  exp_size [4];
    int          exp_n, exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err, exp_split;

    // Derives the expected RAM transactions, latency and result of one
    // request from the access rules, and applies stores to the shadow memory.
    task automatic model_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic sgn);
        int unsigned nb;
        logic [31:0] v;
        logic [7:0]  ix;
        exp_n = 0; exp_rdata = '0; exp_err = 1'b0; exp_split = 1'b0;
        if (size == 2'b11) begin
            exp_err = 1'b1;
            exp_lat = 1;
            return;
        end
        nb = 1 << size;
        exp_split = (addr % nb) != 0;
        if (!exp_split) begin
            exp_n = 1; exp_lat = 2;
            exp_addr[0] = addr; exp_size[0] = size; exp_din[0] = wdata;
        end else begin
            exp_n = nb; exp_lat = nb + 1;
            for (int k = 0; k < int'(nb); k++) begin
                exp_addr[k] = addr + k;
                exp_size[k] = 2'b00;
                exp_din[k]  = (wdata >> (8 * (nb - 1 - k))) & 32'hFF;
            end
        end
        if (rw) begin
            for (int k = 0; k < int'(nb); k++) begin
                ix = 8'(addr + k);
                model_mem[ix] = 8'(wdata >> (8 * (nb - 1 - k)));
            end
        end else begin
            v = '0;
            for (int k = 0; k < int'(nb); k++) begin
                ix = 8'(addr + k);
                v = (v << 8) | {24'h0, model_mem[ix]};
            end
            if (sgn && nb == 1 && v[7])  v = v | 32'hFFFFFF00;
            if (sgn && nb == 2 && v[15]) v = v | 32'hFFFF0000;
            exp_rdata = v;
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pk_we = 1'b1; pk_a = a; pk_d = d;
        model_mem[a] = d;
        @(posedge clk);
        #1 pk_we = 1'b0;
    endtask

    // Issue one request, observe RAM traffic until resp_valid (bounded),
    // and compare traffic and result against the model.
    task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sgn,
                          output int lat, output logic [31:0] rdata, output logic err);
        logic [31:0] o_addr [8];
        logic [31:0] o_din  [8];
        logic [1:0]  o_size [8];
        logic        o_rw   [8];
        int          o_n;
        model_req(rw, addr, wdata, size, sgn);
        o_n = 0; lat = 0; rdata = '0; err = 1'b0;
        @(negedge clk);
        check("ready_before", {31'h0, p.req_ready}, 32'h1);
        p.req_valid = 1'b1; p.req_rw = rw; p.req_addr = addr;
        p.req_wdata = wdata; p.req_size = size; p.req_signed = sgn;
        @(posedge clk);
        #1;
        // Inputs are scrambled after acceptance; the unit must ignore them.
        p.req_valid = 1'b0; p.req_rw = 1'($urandom); p.req_addr = $urandom;
        p.req_wdata = $urandom; p.req_size = 2'($urandom); p.req_signed = 1'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_en && o_n < 8) begin
                o_addr[o_n] = mem_addr; o_din[o_n] = mem_din;
                o_size[o_n] = mem_size; o_rw[o_n] = mem_rw;
                o_n++;
            end
            if (!mem_en) check("rw_without_en", {31'h0, mem_rw}, 32'h0);
            if (p.resp_valid) begin
                lat = k; rdata = p.resp_rdata; err = p.resp_err;
                check("resp_cycle_mem_quiet", {30'h0, mem_en, mem_rw}, 32'h0);
                break;
            end
            check("busy_in_flight", {31'h0, p.busy}, 32'h1);
        end
        @(negedge clk);
        check("idle_after", {27'h0, p.req_ready, p.busy, p.resp_valid, mem_en, mem_rw}, 32'h10);
        check("lat_model", lat, exp_lat);
        check("rdata_model", rdata, exp_rdata);
        check("err_model", {31'h0, err}, {31'h0, exp_err});
        check("txn_count", o_n, exp_n);
        for (int k = 0; k < exp_n && k < o_n; k++) begin
            check($sformatf("txn%0d_addr", k), o_addr[k], exp_addr[k]);
            check($sformatf("txn%0d_size", k), {30'h0, o_size[k]}, {30'h0, exp_size[k]});
            check($sformatf("txn%0d_rw", k), {31'h0, o_rw[k]}, {31'h0, rw});
            if (rw && exp_split)  check($sformatf("txn%0d_din", k), o_din[k] & 32'hFF, exp_din[k]);
            if (rw && !exp_split) check($sformatf("txn%0d_din", k), o_din[k], exp_din[k]);
        end
    endtask

    // ---------------- directed vectors ------------------------------------
    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        int          exp_lat;
        logic        exp_err;
    } vec2_t;

    vec_t  vecs [13];
    vec2_t v2   [3];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic [6:0]  mask;
        logic        en_seen;

        vecs[0]  = '{1'b0, 32'h00000010, 32'h0,        2'b10, 1'b0, 32'h80112233, 1'b0, 2};
        vecs[1]  = '{1'b0, 32'h00000010, 32'h0,        2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 2};
        vecs[2]  = '{1'b0, 32'h00000010, 32'h0,        2'b00, 1'b0, 32'h00000080, 1'b0, 2};
        vecs[3]  = '{1'b0, 32'h00000012, 32'h0,        2'b01, 1'b1, 32'h00002233, 1'b0, 2};
        vecs[4]  = '{1'b0, 32'h00000010, 32'h0,        2'b01, 1'b1, 32'hFFFF8011, 1'b0, 2};
        vecs[5]  = '{1'b1, 32'h00000021, 32'hA1B2C3D4, 2'b10, 1'b0, 32'h00000000, 1'b0, 5};
        vecs[6]  = '{1'b0, 32'h00000021, 32'h0,        2'b10, 1'b0, 32'hA1B2C3D4, 1'b0, 5};
        vecs[7]  = '{1'b0, 32'h00000011, 32'h0,        2'b01, 1'b1, 32'h00001122, 1'b0, 3};
        vecs[8]  = '{1'b1, 32'h00000030, 32'h12345678, 2'b11, 1'b0, 32'h00000000, 1'b1, 1};
        vecs[9]  = '{1'b0, 32'h00000010, 32'h0,        2'b11, 1'b1, 32'h00000000, 1'b1, 1};
        vecs[10] = '{1'b1, 32'hFFFFFFFF, 32'h0000BEEF, 2'b01, 1'b0, 32'h00000000, 1'b0, 3};
        vecs[11] = '{1'b0, 32'hFFFFFFFF, 32'h0,        2'b01, 1'b1, 32'hFFFFBEEF, 1'b0, 3};
        vecs[12] = '{1'b0, 32'h00000011, 32'h0,        2'b00, 1'b1, 32'h00000011, 1'b0, 2};

        v2[0] = '{32'h00000011, 2'b01, 1, 1'b1};
        v2[1] = '{32'h00000013, 2'b10, 1, 1'b1};
        v2[2] = '{32'h00000014, 2'b10, 2, 1'b0};

        reset = 1'b1;
        p.req_valid = 1'b0; p.req_rw = 1'b0; p.req_addr = '0;
        p.req_wdata = '0; p.req_size = '0; p.req_signed = 1'b0;
        p2.req_valid = 1'b0; p2.req_rw = 1'b0; p2.req_addr = '0;
        p2.req_wdata = '0; p2.req_size = '0; p2.req_signed = 1'b0;

        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
        poke(8'h10, 8'h80); poke(8'h11, 8'h11); poke(8'h12, 8'h22); poke(8'h13, 8'h33);

        @(negedge clk);
        check("reset_ready_busy", {30'h0, p.req_ready, p.busy}, 32'h2);
        check("reset_resp", {30'h0, p.resp_valid, p.resp_err}, 32'h0);
        check("reset_rdata", p.resp_rdata, 32'h0);
        check("reset_mem_ctl", {28'h0, mem_en, mem_rw, mem_size}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_din", mem_din, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sgn, lat, rd, er);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
        end

        // Back-to-back aligned loads with req_valid held: pulses 3 cycles apart.
        @(negedge clk);
        p.req_valid = 1'b1; p.req_rw = 1'b0; p.req_addr = 32'h10;
        p.req_size = 2'b10; p.req_signed = 1'b0;
        mask = '0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            mask[c-1] = p.resp_valid;
            if (p.resp_valid) check("b2b_rdata", p.resp_rdata, 32'h80112233);
        end
        p.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_pulse_pattern", {25'h0, mask}, 32'h12);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            do_req(1'($urandom), 32'h40 + $urandom_range(0, 127), $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom), lat, rd, er);
        end

        // ALLOW_UNALIGNED=0 instance: unaligned rejected without RAM traffic.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            p2.req_valid = 1'b1; p2.req_rw = 1'b0; p2.req_addr = v2[i].addr;
            p2.req_size = v2[i].size; p2.req_signed = 1'b1;
            @(posedge clk);
            #1 p2.req_valid = 1'b0;
            en_seen = 1'b0; lat = 0; er = 1'b0; rd = '0;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                en_seen = en_seen | m2_en;
                if (p2.resp_valid) begin
                    lat = k; er = p2.resp_err; rd = p2.resp_rdata;
                    break;
                end
            end
            check($sformatf("strict%0d_lat", i), lat, v2[i].exp_lat);
            check($sformatf("strict%0d_err", i), {31'h0, er}, {31'h0, v2[i].exp_err});
            check($sformatf("strict%0d_mem_en", i), {31'h0, en_seen}, {31'h0, !v2[i].exp_err});
            check($sformatf("strict%0d_rdata", i), rd, 32'h0);
            @(negedge clk);
        end

        // Reset during the 3rd byte of a split word store.
        poke(8'h21, 8'h00); poke(8'h22, 8'h00); poke(8'h23, 8'h00); poke(8'h24, 8'h55);
        @(negedge clk);
        p.req_valid = 1'b1; p.req_rw = 1'b1; p.req_addr = 32'h21;
        p.req_wdata = 32'hA1B2C3D4; p.req_size = 2'b10; p.req_signed = 1'b0;
        @(posedge clk);
        #1 p.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_third_byte_addr", mem_addr, 32'h23);
        reset = 1'b1;
        #1;
        check("abort_mem_quiet", {30'h0, mem_en, mem_rw}, 32'h0);
        check("abort_no_resp", {31'h0, p.resp_valid}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_resp_hold", {31'h0, p.resp_valid}, 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", {30'h0, p.req_ready, p.resp_valid}, 32'h2);
        check("abort_byte21", {24'h0, ram[8'h21]}, 32'hA1);
        check("abort_byte22", {24'h0, ram[8'h22]}, 32'hB2);
        check("abort_byte23", {24'h0, ram[8'h23]}, 32'h00);
        check("abort_byte24", {24'h0, ram[8'h24]}, 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
